// File: rtl/mfp_uart_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mfp_uart_transmitter
//
// Purpose: serial UART transmitter. Accepts one byte per valid/ready handshake
// and shifts it out LSB-first as 8N1, or as 8E1 when MFP_UART_TX_PARITY_EN is
// defined at compile time (adds an even-parity bit between bit 7 and stop).
//
// Parameters:
//   CLK_FREQ_HZ : clock frequency in Hz
//   BAUD_RATE   : line rate in bit/s; DIV = CLK_FREQ_HZ / BAUD_RATE (>= 2)
//
// Ports:
//   clock    : system clock
//   reset    : synchronous active-high reset
//   tx_data  : byte to send, sampled only on acceptance
//   tx_valid : send request
//   tx_ready : high only while idle; accept on tx_valid && tx_ready
//   tx_busy  : inverse of tx_ready
//   tx_done  : one-cycle pulse in the last cycle of the stop bit
//   tx       : registered serial line, idles high
//
// Configuration macro: MFP_UART_TX_PARITY_EN
// -----------------------------------------------------------------------------
module mfp_uart_transmitter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("mfp_uart_transmitter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MFP_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;
`ifdef MFP_UART_TX_PARITY_EN
  // Parity is captured at acceptance because the shift register is consumed
  // while the data bits go out.
  logic             par_q, par_d;
`endif

  assign bit_end  = (cnt_q == CNT_LAST);
  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = !tx_ready;
  assign tx_done  = (state_q == S_STOP) && bit_end;
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef MFP_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // Every non-idle state runs the baud counter; it wraps on the last cycle
    // of each bit period.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef MFP_UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The line register is loaded from the next state so the line level
    // changes on the same edge as the state.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef MFP_UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef MFP_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mfp_uart_transmitter
//
// Purpose: self-checking bench for mfp_uart_transmitter with DIV = 10.
// A frame-level reference model predicts every output each cycle from the
// accepted byte and the number of cycles elapsed since acceptance.
// -----------------------------------------------------------------------------
module tb_mfp_uart_transmitter;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx;

  mfp_uart_transmitter #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clock = ~clock;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit   m_busy = 0;
  int   m_c = 0;           // cycle number within the frame, 1..F*DIV
  logic m_bits [0:10];     // frame bit sequence, start first
  int   cyc = 0;
  int   frames_acc = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  int   acc_cyc [$];

  initial begin
    forever begin
      logic e_tx, e_done;
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_busy = 0;
        m_c    = 0;
      end else if (!m_busy) begin
        if (tx_valid) begin
          m_busy = 1;
          m_c    = 1;
          m_bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[1+i] = tx_data[i];
`ifdef MFP_UART_TX_PARITY_EN
          m_bits[9] = ^tx_data;
`endif
          m_bits[F-1] = 1'b1;
          frames_acc++;
          acc_cyc.push_back(cyc);
          $display("accept byte=%02h cycle=%0d", tx_data, cyc);
        end
      end else if (m_c == F*DIV) begin
        m_busy = 0;
      end else begin
        m_c++;
      end
      #1;
      e_tx   = m_busy ? m_bits[(m_c-1)/DIV] : 1'b1;
      e_done = m_busy && (m_c == F*DIV);
      if (e_done) done_exp++;
      if (tx_done === 1'b1) begin
        done_seen++;
        $display("done cycle=%0d", cyc);
      end
      check_value("tx", tx, e_tx);
      check_value("tx_ready", tx_ready, !m_busy);
      check_value("tx_busy", tx_busy, m_busy);
      check_value("tx_done", tx_done, e_done);
    end
  end

  // ---------------- stimulus ----------------
  int n_sent = 0;

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_value("ready_timeout", tx_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    n_sent++;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    // reset held for three cycles
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // single frame 0x55
    send(8'h55);
    wait_ready(300);

    // back-to-back with data change mid-frame
    @(negedge clock);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    n_sent++;
    @(negedge clock);
    repeat (29) @(negedge clock);
    tx_data = 8'h3C;
    wait_ready(300);
    @(negedge clock);
    tx_valid = 1'b0;
    n_sent++;
    check_value("b2b_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], F*DIV + 1);
    wait_ready(300);

    // reset at cycle 45 of a 0xFF frame, then 0x01
    send(8'hFF);
    repeat (44) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_value("reset_ready", tx_ready, 1'b1);
    check_value("reset_tx", tx, 1'b1);
    send(8'h01);
    wait_ready(300);

    // parity patterns
    send(8'h07);
    wait_ready(300);
    send(8'h03);
    wait_ready(300);

    // valid pulse while busy is ignored
    send(8'h81);
    repeat (20) @(negedge clock);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    wait_ready(300);

    // randomized frames with random idle gaps and busy-time pulses
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      send(rb);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 80)) @(negedge clock);
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
      end
      wait_ready(300);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    check_value("frames_accepted", frames_acc, n_sent);
    check_value("done_count", done_seen, done_exp);
    check_value("done_total", done_seen, n_sent - 1);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
